intt_core_arbiter: RTL and testbench

// - Shares one polynomial INTT core (256 x 16-bit coeffs) among NUM_REQ requesters.

---
 rtl/intt_core_arbiter_pkg.sv | 7 +
 rtl/intt_core_arbiter_if.sv | 11 +
 rtl/intt_core_arbiter_rr_pick.sv | 22 ++
 rtl/intt_core_arbiter.sv | 104 ++++++++++
 tb/tb_intt_core_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/intt_core_arbiter_pkg.sv
// kyber_intt_pkg: shared INTT sizes, arbiter state encoding and watchdog default.
package kyber_intt_pkg;
  localparam int KYBER_N = 256;
  localparam int COEFF_W = 16;
  localparam int INTT_ARB_TIMEOUT = 4095;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, RESP = 2'd3} arb_state_t;
endpackage

// File: rtl/intt_core_arbiter_if.sv
// intt_core_arbiter_if: requester-side request/grant and response channel of the INTT arbiter.
interface intt_core_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int POLY_W = kyber_intt_pkg::KYBER_N * kyber_intt_pkg::COEFF_W
);
  logic [NUM_REQ-1:0] req, gnt, rsp_valid, rsp_ready;
  logic [NUM_REQ*POLY_W-1:0] req_poly;
  logic [POLY_W-1:0] rsp_poly;
  modport master (output req, req_poly, rsp_ready, input gnt, rsp_valid, rsp_poly);
  modport slave (input req, req_poly, rsp_ready, output gnt, rsp_valid, rsp_poly);
endinterface

// File: rtl/intt_core_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr with wrap.
module rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] j;
  // Scan offsets high to low so the closest request to ptr is assigned last.
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) idx_o = j;
    end
  end
  assign gnt_o = |req_i ? (NUM_REQ'(1) << idx_o) : '0;
endmodule

// File: rtl/intt_core_arbiter.sv
// intt_core_arbiter: round-robin sharing of one INTT core, one transform per grant.
// Optional BUSY watchdog enabled by INTT_ARB_TIMEOUT_EN.
module intt_core_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int COEFF_W = kyber_intt_pkg::COEFF_W,
  parameter int KYBER_N = kyber_intt_pkg::KYBER_N,
  parameter int POLY_W = COEFF_W * KYBER_N,
  parameter int TIMEOUT_CYC = kyber_intt_pkg::INTT_ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  intt_core_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              err_o,
  output logic              core_enable_o,
  output logic [POLY_W-1:0] core_ipoly_o,
  input  logic              core_done_i,
  input  logic [POLY_W-1:0] core_opoly_i
);
  import kyber_intt_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 4095) begin : g_bad_cfg
    $error("intt_core_arbiter: parameter out of range");
  end
  arb_state_t         state_q;
  logic [IW-1:0]      owner_q, rr_q, rr_d, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, gnt_q, rsp_valid_q;
  logic [POLY_W-1:0]  rsp_poly_q, core_ipoly_q;
  logic               core_enable_q;
`ifdef INTT_ARB_TIMEOUT_EN
  logic [11:0]        wd_q;
  logic               err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i(bus.req),
    .ptr_i(rr_q),
    .gnt_o(pick_oh),
    .idx_o(pick_idx)
  );
  assign rr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      gnt_q <= '0;
      rsp_valid_q <= '0;
      rsp_poly_q <= '0;
      core_ipoly_q <= '0;
      core_enable_q <= 1'b0;
`ifdef INTT_ARB_TIMEOUT_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      gnt_q <= '0;
      core_enable_q <= 1'b0;
`ifdef INTT_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (|bus.req) begin
          owner_q <= pick_idx;
          core_ipoly_q <= bus.req_poly[int'(pick_idx)*POLY_W +: POLY_W];
          gnt_q <= pick_oh;
          state_q <= START;
        end
        START: begin
          core_enable_q <= 1'b1;
          state_q <= BUSY;
`ifdef INTT_ARB_TIMEOUT_EN
          wd_q <= '0;
`endif
        end
        BUSY: if (core_done_i) begin
          rsp_poly_q <= core_opoly_i;
          rsp_valid_q <= NUM_REQ'(1) << owner_q;
          state_q <= RESP;
        end
`ifdef INTT_ARB_TIMEOUT_EN
        else if (wd_q == 12'(TIMEOUT_CYC - 1)) begin
          err_q <= 1'b1;
          rr_q <= rr_d;
          state_q <= IDLE;
        end else wd_q <= wd_q + 1'b1;
`endif
        RESP: if (bus.rsp_ready[owner_q]) begin
          rsp_valid_q <= '0;
          rr_q <= rr_d;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_poly = rsp_poly_q;
  assign busy_o = state_q != IDLE;
  assign core_enable_o = core_enable_q;
  assign core_ipoly_o = core_ipoly_q;
endmodule

// File: tb/tb_intt_core_arbiter.sv
// tb_intt_core_arbiter: directed checks of grant order, core handshake, response hold and reset.
module tb_intt_core_arbiter;
  localparam int N = 3;
  localparam int PW = 4096;
  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, err, core_enable, core_done, never_done = 1'b0;
  logic [PW-1:0] core_ipoly, core_opoly;
  logic active = 1'b0;
  logic [4:0] cnt = '0;
  logic onehot_bad = 1'b0;
  int checks = 0, failures = 0;
  logic [N-1:0] g;
  intt_core_arbiter_if #(.NUM_REQ(N), .POLY_W(PW)) bus ();
  intt_core_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .err_o(err),
    .core_enable_o(core_enable), .core_ipoly_o(core_ipoly),
    .core_done_i(core_done), .core_opoly_i(core_opoly)
  );
  always #5 clk = ~clk;
  function automatic logic [PW-1:0] fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) fill[i*16 +: 16] = v;
  endfunction
  // Core model: done exactly 20 cycles after the enable cycle, result = input ^ 0xA5A5.
  assign core_done = active && cnt == 0;
  always @(posedge clk) begin
    if (!rst_n) active <= 1'b0;
    else if (core_enable && !never_done) begin
      active <= 1'b1;
      cnt <= 5'd19;
      core_opoly <= core_ipoly ^ fill(16'hA5A5);
    end else if (core_done) active <= 1'b0;
    else if (active) cnt <= cnt - 1'b1;
  end
  always @(negedge clk)
    if ($countones(bus.gnt) > 1 || $countones(bus.rsp_valid) > 1) onehot_bad <= 1'b1;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_poly(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask
  task automatic wait_gnt(output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (bus.gnt != 0) begin
        got = bus.gnt;
        break;
      end
    end
  endtask
  task automatic wait_rsp();
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (bus.rsp_valid != 0) break;
    end
  endtask
  initial begin
    bus.req = '0;
    bus.rsp_ready = '0;
    bus.req_poly = {fill(16'h0030), fill(16'h0001), fill(16'h0010)};
    cyc();
    cyc();
    check("reset_outputs", 64'({bus.gnt, bus.rsp_valid, busy, err, core_enable}), 64'd0);
    check_poly("reset_ipoly", core_ipoly, '0);
    rst_n = 1'b1;
    cyc();
    // Single request from requester 1.
    bus.req = 3'b010;
    cyc();
    check("single_gnt", 64'(bus.gnt), 64'(3'b010));
    check("single_enable_not_yet", 64'({busy, core_enable}), 64'(2'b10));
    check_poly("single_ipoly", core_ipoly, fill(16'h0001));
    bus.req = '0;
    cyc();
    check("single_enable", 64'({bus.gnt, core_enable}), 64'(4'b0001));
    repeat (20) cyc();
    check("single_no_early_rsp", 64'(bus.rsp_valid), 64'd0);
    cyc();
    check("single_rsp_valid", 64'(bus.rsp_valid), 64'(3'b010));
    check_poly("single_rsp_poly", bus.rsp_poly, fill(16'hA5A4));
    // Response held while ready is low; a pending request must wait.
    bus.req = 3'b001;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_state", 64'({bus.gnt, busy, bus.rsp_valid}), 64'({3'b000, 1'b1, 3'b010}));
      check_poly("hold_poly", bus.rsp_poly, fill(16'hA5A4));
    end
    bus.rsp_ready = 3'b101;
    cyc();
    check("nonowner_ready_ignored", 64'(bus.rsp_valid), 64'(3'b010));
    bus.rsp_ready = 3'b010;
    cyc();
    check("handshake_clear", 64'({bus.rsp_valid, bus.gnt, busy}), 64'd0);
    bus.rsp_ready = '0;
    cyc();
    check("gnt_after_handshake", 64'(bus.gnt), 64'(3'b001));
    // All requesting: rotation continues from requester 0.
    bus.req = 3'b111;
    bus.rsp_ready = 3'b111;
    wait_gnt(g);
    check("rr_1", 64'(g), 64'(3'b010));
    wait_gnt(g);
    check("rr_2", 64'(g), 64'(3'b100));
    wait_gnt(g);
    check("rr_0", 64'(g), 64'(3'b001));
    wait_gnt(g);
    check("rr_1b", 64'(g), 64'(3'b010));
    bus.req = 3'b100;
    wait_gnt(g);
    check("rr_2b", 64'(g), 64'(3'b100));
    bus.req = '0;
    bus.rsp_ready = 3'b001;
    wait_rsp();
    check("owner2_rsp", 64'(bus.rsp_valid), 64'(3'b100));
    check_poly("owner2_poly", bus.rsp_poly, fill(16'hA595));
    repeat (3) cyc();
    check("owner2_ready0_ignored", 64'(bus.rsp_valid), 64'(3'b100));
    bus.rsp_ready = 3'b100;
    cyc();
    check("owner2_done", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = '0;
    // Reset in BUSY aborts the transform.
    bus.req = 3'b001;
    cyc();
    check("pre_reset_gnt", 64'(bus.gnt), 64'(3'b001));
    bus.req = '0;
    repeat (6) cyc();
    rst_n = 1'b0;
    cyc();
    check("midreset_outputs", 64'({bus.gnt, bus.rsp_valid, busy, err, core_enable}), 64'd0);
    check_poly("midreset_ipoly", core_ipoly, '0);
    rst_n = 1'b1;
    bus.req_poly[2*PW +: PW] = fill(16'h0007);
    bus.req = 3'b100;
    cyc();
    check("post_reset_gnt", 64'(bus.gnt), 64'(3'b100));
    bus.req = '0;
    wait_rsp();
    check("post_reset_rsp", 64'(bus.rsp_valid), 64'(3'b100));
    check_poly("post_reset_poly", bus.rsp_poly, fill(16'hA5A2));
    bus.rsp_ready = 3'b100;
    cyc();
    bus.rsp_ready = '0;
    check("post_reset_done", 64'({bus.rsp_valid, busy}), 64'd0);
`ifdef INTT_ARB_TIMEOUT_EN
    never_done = 1'b1;
    bus.req = 3'b001;
    cyc();
    check("to_gnt", 64'(bus.gnt), 64'(3'b001));
    bus.req = 3'b010;
    cyc();
    check("to_enable", 64'(core_enable), 64'd1);
    begin
      logic early = 1'b0;
      for (int i = 0; i < 4094; i++) begin
        cyc();
        if (err || bus.gnt != 0) early = 1'b1;
      end
      check("to_no_early_err", 64'(early), 64'd0);
    end
    cyc();
    check("to_err", 64'({err, busy, bus.rsp_valid}), 64'({1'b1, 1'b0, 3'b000}));
    cyc();
    check("to_next_gnt", 64'({err, bus.gnt}), 64'({1'b0, 3'b010}));
    bus.req = '0;
`endif
    check("onehot_outputs", 64'(onehot_bad), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
